uart_byte_fifo: RTL and testbench
=================================

Name: uart_byte_fifo

Overview:
Byte FIFO placed between uart_rx and uart_tx in the loopback/echo path. It absorbs the one-cycle valid pulses from the receiver. It then drives the transmitter's data_we/data_wait handshake, so back-to-back received bytes are not lost while the transmitter is still shifting out an earlier byte. It also exposes occupancy and a sticky overflow flag for debug/LEDs.

Parameters:
DEPTH_LOG2, 4, log2 of entry count (DEPTH = 2**DEPTH_LOG2 = 16 entries)
DATA_W, 8, width of one entry in bits

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  synchronous, active-low reset
wr_valid  input  1  one-cycle push strobe (connects to uart_rx valid)
wr_data  input  DATA_W  byte to push, sampled when wr_valid=1
tx_we  output  1  write request to transmitter (connects to uart_tx data_we)
tx_data  output  DATA_W  head-of-queue byte (connects to uart_tx data)
tx_wait  input  1  transmitter busy (uart_tx data_wait); combinational from tx_we
count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky: a push was dropped
overflow_clr  input  1  one-cycle clear of overflow

Behaviour:
- Storage: DEPTH x DATA_W array with asynchronous read. No reset on array contents.
- Pointers: wr_ptr and rd_ptr, DEPTH_LOG2+1 bits each, incrementing modulo 2**(DEPTH_LOG2+1).
  - Index = low DEPTH_LOG2 bits.
  - count = wr_ptr - rd_ptr, truncated to DEPTH_LOG2+1 bits.
  - empty = (wr_ptr==rd_ptr).
  - full = (index bits equal AND MSBs differ).
- Reset (resetn=0 at a clk edge): wr_ptr=0, rd_ptr=0, overflow=0. Resulting outputs: count=0, empty=1, full=0, tx_we=0. tx_data is don't-care while tx_we=0. Reset wins over all other inputs in the same cycle, including mid-transfer; a byte already handed to uart_tx is not recalled.
- tx_we = !empty (combinational from registered pointers). tx_data = mem[rd_ptr index].
- Pop: occurs on an edge where tx_we=1 and tx_wait=0; rd_ptr increments. Matches the uart_tx acceptance rule (data_we && bitcnt==0). tx_we stays high with a stable tx_data while tx_wait=1.
- Push: occurs on an edge where wr_valid=1 and (!full OR pop in the same cycle). mem[wr_ptr]<=wr_data, wr_ptr increments.
- Push while full with no pop: byte dropped, pointers unchanged, overflow<=1.
- Simultaneous push+pop:
  - When full: both occur, count unchanged, no overflow.
  - When empty: pop cannot occur (tx_we=0); push only.
- Latency: a byte pushed into an empty FIFO appears on tx_we/tx_data on the cycle after the push edge. There is no same-cycle fall-through.
- overflow: set has priority over overflow_clr when both occur in the same cycle. Otherwise overflow_clr=1 clears it on the next edge.
- Ordering: strict FIFO. Wrap-around of index bits is transparent.
- Throughput: at most one push and one pop per cycle.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with wr_valid=1 -> count=0, empty=1, tx_we=0, overflow=0 after release.
2. Single byte: tx_wait tied to tx_we && busy model; push 8'hA5 at cycle N -> tx_we=1 and tx_data=8'hA5 at N+1; with tx_wait=0, popped at N+1 edge; empty=1 at N+2.
3. Fill and overflow: tx_wait=1 constantly; push 0x00..0x10 (17 bytes) -> after 16 pushes full=1, count=16; 17th dropped, overflow=1; then release tx_wait -> pops output 0x00..0x0F in order, 0x10 never appears.
4. Full + simultaneous push/pop: at full, push 8'h5A in the same cycle tx_wait=0 -> count stays 16, overflow stays 0, 8'h5A emerges last after 15 further pops.
5. Wrap-around: uart_tx model busy 10*D cycles per byte (D=4); push 40 random bytes at random gaps keeping count<=16 -> output sequence equals input sequence, count never exceeds 16, overflow=0.
6. Reset mid-operation: with count=7 and a pop in progress, assert resetn=0 for one edge -> count=0, tx_we=0 next cycle; subsequent push 8'h3C emerges as the first byte. Also assert overflow_clr together with a dropped push -> overflow remains 1.

Source files
------------

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx so back-to-back received bytes survive a busy transmitter.
// Latency: a byte pushed into an empty FIFO shows on tx_we/tx_data the cycle after the push edge.
// Backpressure: tx_wait holds the head byte; a push while full with no pop is dropped and sets sticky overflow.
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  tx_we,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_wait,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

  // Status and handshake decode from the registered pointers; the extra MSB
  // separates full from empty when the index bits coincide.
  always_comb begin
    count   = wr_ptr - rd_ptr;
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_idx == rd_idx) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    tx_we   = !empty;
    tx_data = mem[rd_idx];
    // A pop frees the slot being written, so a push into a full FIFO is
    // accepted when the transmitter takes the head in the same cycle.
    pop     = tx_we && !tx_wait;
    push    = wr_valid && (!full || pop);
    drop    = wr_valid && full && !pop;
  end

  // Storage: written on accepted pushes only, no reset on contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Pointer and sticky overflow state; reset overrides any transfer in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Randomized bench for uart_byte_fifo against a queue-based reference model.
// Inputs change on the falling edge; outputs are compared on the next falling edge.
// The transmitter is modelled as busy for a fixed number of cycles after each accepted byte.
module tb_uart_byte_fifo;

  localparam int DEPTH   = 16;
  localparam int TX_BUSY = 40;

  logic       clk;
  logic       resetn;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       tx_we;
  logic [7:0] tx_data;
  logic       tx_wait;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       overflow_clr;

  uart_byte_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .tx_we        (tx_we),
    .tx_data      (tx_data),
    .tx_wait      (tx_wait),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: queue contents and sticky overflow bit.
  logic [7:0] q[$];
  logic       m_ovf;
  // Bytes the DUT handed to the transmitter, in order.
  logic [7:0] popped[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".tx_we"}, 32'(tx_we), 32'(q.size() != 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) check({tag, ".tx_data"}, 32'(tx_data), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model by the rules, then compare.
  task automatic step(input string tag, input logic rn, input logic wv, input logic [7:0] wd,
                      input logic tw, input logic clr);
    bit will_pop;
    bit was_full;
    resetn       = rn;
    wr_valid     = wv;
    wr_data      = wd;
    tx_wait      = tw;
    overflow_clr = clr;
    will_pop = (q.size() != 0) && !tw;
    was_full = (q.size() == DEPTH);
    if (rn && will_pop) popped.push_back(tx_data);
    if (!rn) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (will_pop) void'(q.pop_front());
      if (wv && (!was_full || will_pop)) q.push_back(wd);
      if (wv && was_full && !will_pop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  logic [7:0] in_bytes[$];
  logic [7:0] b;
  int busy;
  int idx;
  int cyc;
  bit pushed_ok;

  initial begin
    resetn = 1'b0; wr_valid = 1'b0; wr_data = '0; tx_wait = 1'b0; overflow_clr = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);

    // 1. Reset held three cycles with pushes requested.
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    check("reset_count", 32'(count), 0);
    check("reset_txwe", 32'(tx_we), 0);
    step("idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // 2. Single byte: visible next cycle, popped on that edge, empty after.
    step("single_push", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_txdata", 32'(tx_data), 32'h A5);
    check("single_txwe", 32'(tx_we), 1);
    popped.delete();
    step("single_pop", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("single_empty", 32'(empty), 1);
    check("single_popped", 32'(popped.size() == 1 ? popped[0] : 8'hFF), 32'hA5);

    // 3. Fill with a stalled transmitter, then one too many.
    for (int i = 0; i <= 16; i++) step("fill", 1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
    check("fill_count", 32'(count), 16);
    check("fill_full", 32'(full), 1);
    check("fill_ovf", 32'(overflow), 1);
    popped.delete();
    for (int i = 0; i < 16; i++) step("drain", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("drain_n", 32'(popped.size()), 16);
    for (int i = 0; i < 16 && i < popped.size(); i++) check("drain_order", 32'(popped[i]), 32'(i));
    step("ovf_clr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overflow), 0);

    // 4. Full plus simultaneous push and pop.
    for (int i = 0; i < 16; i++) step("fill2", 1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
    step("full_pushpop", 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    check("pp_count", 32'(count), 16);
    check("pp_ovf", 32'(overflow), 0);
    popped.delete();
    for (int i = 0; i < 16; i++) step("drain2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("pp_last", 32'(popped.size() == 16 ? popped[15] : 8'h00), 32'h5A);

    // 5. Random traffic through a slow transmitter; index bits wrap many times.
    in_bytes.delete();
    popped.delete();
    busy = 0;
    idx  = 0;
    cyc  = 0;
    while ((idx < 40 || q.size() != 0) && cyc < 5000) begin
      bit wv;
      bit tw;
      bit pop_now;
      wv = (idx < 40) && (q.size() < DEPTH) && ($urandom_range(0, 3) == 0);
      b  = 8'($urandom);
      tw = (q.size() != 0) && (busy > 0);
      pop_now = (q.size() != 0) && !tw;
      if (wv) begin
        in_bytes.push_back(b);
        idx++;
      end
      step("rand", 1'b1, wv, b, tw, 1'b0);
      if (pop_now) busy = TX_BUSY;
      else if (busy > 0) busy--;
      cyc++;
    end
    check("rand_done", 32'(cyc < 5000), 1);
    check("rand_n", 32'(popped.size()), 40);
    for (int i = 0; i < 40 && i < popped.size(); i++) check("rand_order", 32'(popped[i]), 32'(in_bytes[i]));
    check("rand_ovf", 32'(overflow), 0);

    // 6. Reset in the middle of a transfer, then clear racing a drop.
    for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
    check("pre_rst_count", 32'(count), 7);
    step("mid_rst", 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_txwe", 32'(tx_we), 0);
    step("post_rst_push", 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
    check("post_rst_head", 32'(tx_data), 32'h3C);
    for (int i = 0; i < 15; i++) step("fill3", 1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
    step("drop_clr", 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    check("drop_clr_ovf", 32'(overflow), 1);
    step("clr_only", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("clr_only_ovf", 32'(overflow), 0);
    pushed_ok = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
